ps2_kbd_ctrl: RTL and testbench
===============================

// Module: ps2_kbd_ctrl
// PURPOSE
//  Sequencer between ps2_keyboard (byte FIFO) and the consumer. Pops scan-code bytes via
//  the ready/nextdata_n handshake, folds E0 (extended) and F0 (break) prefixes into one
//  key event, and tags typematic repeats. Presents events on a valid/ready port.
//  Counts make events and latches keyboard overflow.
// PARAMETERS
//  SUPPRESS_RPT  1  1: drop repeated make codes of the held key; 0: emit them with evt_repeat=1
//  CNT_W         8  width of press_cnt and err_cnt (both wrap modulo 2^CNT_W)
// PORTS
//  clk           in   1      system clock; all state on rising edge
//  clrn          in   1      reset, asynchronous, active-low
//  kbd_data      in   8      ps2_keyboard data (FIFO head)
//  kbd_ready     in   1      ps2_keyboard ready: kbd_data valid
//  kbd_overflow  in   1      ps2_keyboard overflow
//  kbd_nextdata_n out 1      pop strobe to ps2_keyboard, registered, active-low
//  evt_valid     out  1      key event available
//  evt_ready     in   1      consumer accepts event when evt_valid&evt_ready
//  evt_code      out  8      scan code (prefixes stripped)
//  evt_ext       out  1      event was E0-prefixed
//  evt_break     out  1      1 = release, 0 = press
//  evt_repeat    out  1      press of key already held (only when SUPPRESS_RPT=0)
//  key_held      out  1      a key is currently held (last make, no matching break yet)
//  press_cnt     out  CNT_W  count of emitted non-repeat press events
//  err_cnt       out  CNT_W  count of 8'h00 / 8'hFF error bytes received
//  ovf_flag      out  1      sticky: set when kbd_overflow=1, cleared by clr_ovf
//  clr_ovf       in   1      clears ovf_flag (set wins if both in same cycle)
// BEHAVIOUR
//  Reset: state IDLE; kbd_nextdata_n=1, evt_valid=0, evt_code=0, evt_ext/break/repeat=0,
//   key_held=0, press_cnt=0, err_cnt=0, ovf_flag=0; prefix flags, held code cleared.
//   clrn low mid-event abandons any captured byte/pending event; no pop is issued.
//  FSM: IDLE -> POP -> DECODE -> (IDLE | EMIT); EMIT -> IDLE on accept.
//   IDLE: if kbd_ready: byte_r<=kbd_data, kbd_nextdata_n<=0, ->POP. Else stay.
//   POP: kbd_nextdata_n<=1 (low exactly one cycle per byte), ->DECODE. kbd_ready is
//    not sampled in POP/DECODE, so the FIFO has settled before the next IDLE check.
//   DECODE on byte_r:
//    E0 -> ext_f<=1, ->IDLE.  F0 -> brk_f<=1, ->IDLE.
//    00/FF -> err_cnt++, ext_f<=0, brk_f<=0, ->IDLE (no event).
//    other code c, with key {ext_f,c}:
//     break: if key==held key then key_held<=0; event break=1, repeat=0.
//     make, key_held && key==held key: repeat. SUPPRESS_RPT=1: clear flags, ->IDLE,
//      no event, no count. Else event repeat=1.
//     make otherwise: held key<={ext_f,c}, key_held<=1, press_cnt++, event repeat=0.
//    Event: load evt_* from flags/c, evt_valid<=1, clear ext_f/brk_f, ->EMIT.
//   EMIT: evt_* held stable while evt_valid; on evt_valid&evt_ready: evt_valid<=0, ->IDLE.
//    No pops during EMIT (backpressure held off in the ps2_keyboard FIFO).
//  Throughput: 3 cycles per prefix byte, >=4 per event byte (one accept cycle min).
//  press_cnt/err_cnt wrap FF->00 (CNT_W=8). key_held/held key update in DECODE,
//   not at event acceptance.
//  ovf_flag: set any cycle kbd_overflow=1, independent of FSM; cleared by clr_ovf.
// TESTING
//  1 reset: clrn=0 with kbd_ready=1 -> nextdata_n=1, evt_valid=0, all counters 0.
//  2 bytes 1C / F0,1C, evt_ready=1 -> press{1C,brk0,ext0}, release{1C,brk1};
//    press_cnt=1, key_held 1 then 0; one 1-cycle nextdata_n pulse per byte (3 total).
//  3 SUPPRESS_RPT=1: 1B,1B,1B,F0,1B -> exactly 2 events (press,release), press_cnt=1;
//    SUPPRESS_RPT=0 -> 4 events, 2nd/3rd with evt_repeat=1, press_cnt=1.
//  4 E0,F0,75 -> one event {code 75, ext1, brk1}; then E0,75 vs 75 -> distinct held keys,
//    second is press (not repeat), press_cnt +2.
//  5 backpressure: evt_ready=0 for 20 cycles after 1C with 2 bytes queued -> evt_* stable,
//    nextdata_n stays 1; after accept remaining bytes drain in order.
//  6 00 between F0 and 1C -> err_cnt=1, flags cleared, 1C emitted as press; kbd_overflow
//    pulse -> ovf_flag=1 until clr_ovf; clrn pulse in EMIT -> evt_valid=0 asynchronously.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_ctrl
// Brief    : Pops PS/2 scan-code bytes from ps2_keyboard, folds E0/F0 prefixes
//            into single key events and tags typematic repeats.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_ctrl #(
  parameter int SUPPRESS_RPT = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic             key_held,
  output logic [CNT_W-1:0] press_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             ovf_flag,
  input  logic             clr_ovf
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_pop    = 2'd1;
  localparam logic [1:0] c_st_decode = 2'd2;
  localparam logic [1:0] c_st_emit   = 2'd3;

  localparam logic [7:0] c_byte_ext  = 8'hE0;
  localparam logic [7:0] c_byte_brk  = 8'hF0;
  localparam logic [7:0] c_byte_err0 = 8'h00;
  localparam logic [7:0] c_byte_err1 = 8'hFF;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [7:0]       r_byte;
  logic             r_ext_f;
  logic             r_brk_f;
  logic [8:0]       r_held_key;
  logic             r_key_held;
  logic             r_nextdata_n;
  logic             r_evt_valid;
  logic [7:0]       r_evt_code;
  logic             r_evt_ext;
  logic             r_evt_break;
  logic             r_evt_repeat;
  logic [CNT_W-1:0] r_press_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_ovf_flag;

  logic [8:0]       w_key;
  logic             w_same_key;
  logic             w_is_err;
  logic             w_pop_start;
  logic             w_pop_end;
  logic             w_set_ext;
  logic             w_set_brk;
  logic             w_err;
  logic             w_clr_flags;
  logic             w_release;
  logic             w_new_press;
  logic             w_emit;
  logic             w_accept;

  // A key is identified by its code together with the extended prefix
  assign w_key      = {r_ext_f, r_byte};
  assign w_same_key = r_key_held && (r_held_key == w_key);
  assign w_is_err   = (r_byte == c_byte_err0) || (r_byte == c_byte_err1);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (kbd_ready) w_state_nxt = c_st_pop;
      c_st_pop:    w_state_nxt = c_st_decode;
      c_st_decode: w_state_nxt = w_emit ? c_st_emit : c_st_idle;
      c_st_emit:   if (evt_ready) w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_pop_start = 1'b0;
    w_pop_end   = 1'b0;
    w_set_ext   = 1'b0;
    w_set_brk   = 1'b0;
    w_err       = 1'b0;
    w_clr_flags = 1'b0;
    w_release   = 1'b0;
    w_new_press = 1'b0;
    w_emit      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      c_st_idle: w_pop_start = kbd_ready;
      c_st_pop:  w_pop_end   = 1'b1;
      c_st_decode: begin
        if (r_byte == c_byte_ext) begin
          w_set_ext = 1'b1;
        end else if (r_byte == c_byte_brk) begin
          w_set_brk = 1'b1;
        end else if (w_is_err) begin
          w_err       = 1'b1;
          w_clr_flags = 1'b1;
        end else begin
          w_clr_flags = 1'b1;
          if (r_brk_f) begin
            w_emit    = 1'b1;
            w_release = w_same_key;
          end else if (w_same_key) begin
            w_emit = (SUPPRESS_RPT == 0);
          end else begin
            w_emit      = 1'b1;
            w_new_press = 1'b1;
          end
        end
      end
      c_st_emit: w_accept = evt_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_byte       <= 8'h00;
      r_nextdata_n <= 1'b1;
      r_ext_f      <= 1'b0;
      r_brk_f      <= 1'b0;
      r_held_key   <= 9'h000;
      r_key_held   <= 1'b0;
      r_press_cnt  <= '0;
      r_err_cnt    <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_code   <= 8'h00;
      r_evt_ext    <= 1'b0;
      r_evt_break  <= 1'b0;
      r_evt_repeat <= 1'b0;
    end else begin
      if (w_pop_start) begin
        r_byte       <= kbd_data;
        r_nextdata_n <= 1'b0;
      end else if (w_pop_end) begin
        r_nextdata_n <= 1'b1;
      end

      if (w_set_ext) begin
        r_ext_f <= 1'b1;
      end else if (w_clr_flags) begin
        r_ext_f <= 1'b0;
      end

      if (w_set_brk) begin
        r_brk_f <= 1'b1;
      end else if (w_clr_flags) begin
        r_brk_f <= 1'b0;
      end

      if (w_err) begin
        r_err_cnt <= r_err_cnt + c_cnt_one;
      end

      // Held-key tracking follows the decoded byte stream, not event acceptance
      if (w_release) begin
        r_key_held <= 1'b0;
      end else if (w_new_press) begin
        r_key_held  <= 1'b1;
        r_held_key  <= w_key;
        r_press_cnt <= r_press_cnt + c_cnt_one;
      end

      if (w_emit) begin
        r_evt_valid  <= 1'b1;
        r_evt_code   <= r_byte;
        r_evt_ext    <= r_ext_f;
        r_evt_break  <= r_brk_f;
        r_evt_repeat <= ~r_brk_f & w_same_key;
      end else if (w_accept) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  // Overflow capture runs regardless of the sequencer; set has priority
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ovf_flag <= 1'b0;
    end else if (kbd_overflow) begin
      r_ovf_flag <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf_flag <= 1'b0;
    end
  end

  assign kbd_nextdata_n = r_nextdata_n;
  assign evt_valid      = r_evt_valid;
  assign evt_code       = r_evt_code;
  assign evt_ext        = r_evt_ext;
  assign evt_break      = r_evt_break;
  assign evt_repeat     = r_evt_repeat;
  assign key_held       = r_key_held;
  assign press_cnt      = r_press_cnt;
  assign err_cnt        = r_err_cnt;
  assign ovf_flag       = r_ovf_flag;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_ctrl
// Brief    : Scoreboard bench; channel 0 suppresses repeats, channel 1 tags them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clrn         = 1'b0;
  logic evt_ready    = 1'b1;
  logic kbd_overflow = 1'b0;
  logic clr_ovf      = 1'b0;
  bit   rnd_ready    = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input int ch, input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL ch%0d %s: got %0h expected %0h at %0t", ch, name, act, want, $time);
  endtask

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 evt_ready = ($urandom_range(3) != 0);
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch
    localparam int SUP = (i == 0) ? 1 : 0;

    logic [7:0]  kbd_data  = 8'h00;
    logic        kbd_ready = 1'b0;
    logic        nextdata_n, evt_valid, evt_ext, evt_break, evt_repeat, key_held, ovf_flag;
    logic [7:0]  evt_code, press_cnt, err_cnt;
    logic [10:0] cur;

    logic [7:0]  fifo[$];
    logic [10:0] exp_q[$];
    bit          m_ext, m_brk, m_held_v;
    logic [8:0]  m_held;
    int          m_press, m_err, pops;
    bit          prev_low, hold_chk;
    logic [10:0] hold_val;

    assign cur = {evt_code, evt_ext, evt_break, evt_repeat};

    ps2_kbd_ctrl #(.SUPPRESS_RPT(SUP), .CNT_W(8)) u_dut (
      .clk           (clk),
      .clrn          (clrn),
      .kbd_data      (kbd_data),
      .kbd_ready     (kbd_ready),
      .kbd_overflow  (kbd_overflow),
      .kbd_nextdata_n(nextdata_n),
      .evt_valid     (evt_valid),
      .evt_ready     (evt_ready),
      .evt_code      (evt_code),
      .evt_ext       (evt_ext),
      .evt_break     (evt_break),
      .evt_repeat    (evt_repeat),
      .key_held      (key_held),
      .press_cnt     (press_cnt),
      .err_cnt       (err_cnt),
      .ovf_flag      (ovf_flag),
      .clr_ovf       (clr_ovf)
    );

    // Reference model: interprets the byte stream as key actions on push
    task automatic push(input logic [7:0] b);
      logic [8:0] key;
      fifo.push_back(b);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'h00 || b == 8'hFF) begin
        m_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else begin
        key = {m_ext, b};
        if (m_brk) begin
          exp_q.push_back({b, m_ext, 1'b1, 1'b0});
          if (m_held_v && m_held == key) m_held_v = 1'b0;
        end else if (m_held_v && m_held == key) begin
          if (SUP == 0) exp_q.push_back({b, m_ext, 1'b0, 1'b1});
        end else begin
          m_held   = key;
          m_held_v = 1'b1;
          m_press++;
          exp_q.push_back({b, m_ext, 1'b0, 1'b0});
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    endtask

    task automatic reset_model();
      exp_q.delete();
      fifo.delete();
      m_ext = 0; m_brk = 0; m_held_v = 0; m_held = '0; m_press = 0; m_err = 0;
    endtask

    task automatic check_counts();
      chk(i, "press_cnt", press_cnt, m_press & 255);
      chk(i, "err_cnt", err_cnt, m_err & 255);
      chk(i, "key_held", key_held, m_held_v);
    endtask

    task automatic check_reset();
      chk(i, "rst_nextdata_n", nextdata_n, 1);
      chk(i, "rst_evt_valid", evt_valid, 0);
      chk(i, "rst_evt_fields", cur, 0);
      chk(i, "rst_counts", {press_cnt, err_cnt, key_held, ovf_flag}, 0);
    endtask

    // FIFO model: pops on a low nextdata_n; ready/data change mid-cycle only
    always @(negedge clk) begin
      if (clrn && !nextdata_n) begin
        chk(i, "pop_pulse_1cyc", prev_low, 0);
        chk(i, "pop_nonempty", fifo.size() != 0, 1);
        if (fifo.size() != 0) begin
          void'(fifo.pop_front());
          pops++;
        end
      end
      prev_low  = clrn && !nextdata_n;
      kbd_ready = (fifo.size() != 0);
      kbd_data  = kbd_ready ? fifo[0] : 8'h00;
    end

    // Monitor: compares accepted events, stability and pop blocking under backpressure
    always @(negedge clk) begin
      if (!clrn) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          chk(i, "valid_held", evt_valid, 1);
          if (evt_valid) chk(i, "evt_stable", cur, hold_val);
          chk(i, "no_pop_in_emit", nextdata_n, 1);
        end
        if (evt_valid && evt_ready) begin
          chk(i, "evt_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk(i, "evt", cur, exp_q.pop_front());
        end
        hold_chk = evt_valid && !evt_ready;
        hold_val = cur;
      end
    end
  end

  task automatic push2(input logic [7:0] b);
    g_ch[0].push(b);
    g_ch[1].push(b);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (t < 20000 && !(g_ch[0].fifo.size() == 0 && g_ch[0].exp_q.size() == 0 &&
                          g_ch[1].fifo.size() == 0 && g_ch[1].exp_q.size() == 0)) begin
      @(negedge clk);
      t++;
    end
    chk(9, "drain_in_time", t < 20000, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic counts2();
    g_ch[0].check_counts();
    g_ch[1].check_counts();
  endtask

  task automatic check_ovf(input logic want);
    chk(0, "ovf_flag", g_ch[0].ovf_flag, want);
    chk(1, "ovf_flag", g_ch[1].ovf_flag, want);
  endtask

  initial begin : main
    logic [7:0] codes [5];
    logic [7:0] c;
    int p0, p1, t;
    codes = '{8'h1C, 8'h1B, 8'h2A, 8'h75, 8'h32};

    // Reset with a byte already waiting in the FIFO
    g_ch[0].reset_model();
    g_ch[1].reset_model();
    push2(8'h1C);
    repeat (3) @(negedge clk);
    chk(0, "rst_kbd_ready", g_ch[0].kbd_ready, 1);
    g_ch[0].check_reset();
    g_ch[1].check_reset();
    @(posedge clk) #1 clrn = 1'b1;

    // Press then release of 1C
    wait_drain();
    counts2();
    push2(8'hF0);
    push2(8'h1C);
    wait_drain();
    counts2();
    chk(0, "pops_total", g_ch[0].pops, 3);
    chk(1, "pops_total", g_ch[1].pops, 3);

    // Typematic repeats
    push2(8'h1B); push2(8'h1B); push2(8'h1B); push2(8'hF0); push2(8'h1B);
    wait_drain();
    counts2();

    // Extended break, then extended vs plain key of the same code
    push2(8'hE0); push2(8'hF0); push2(8'h75);
    push2(8'hE0); push2(8'h75);
    push2(8'h75);
    wait_drain();
    counts2();

    // Backpressure with two bytes queued behind the event
    p0 = g_ch[0].pops;
    @(posedge clk) #1 evt_ready = 1'b0;
    push2(8'h1C); push2(8'h2A); push2(8'h32);
    repeat (26) @(negedge clk);
    chk(0, "bp_queued", g_ch[0].fifo.size(), 2);
    chk(1, "bp_queued", g_ch[1].fifo.size(), 2);
    chk(0, "bp_valid", g_ch[0].evt_valid, 1);
    chk(0, "bp_pops", g_ch[0].pops - p0, 1);
    @(posedge clk) #1 evt_ready = 1'b1;
    wait_drain();
    counts2();

    // Error byte between break prefix and code
    push2(8'hF0); push2(8'h00); push2(8'h1C);
    wait_drain();
    counts2();

    // Overflow sticky flag
    @(posedge clk) #1 kbd_overflow = 1'b1;
    @(posedge clk) #1 kbd_overflow = 1'b0;
    @(negedge clk) check_ovf(1'b1);
    repeat (5) @(negedge clk);
    check_ovf(1'b1);
    @(posedge clk) #1 clr_ovf = 1'b1;
    @(posedge clk) #1 clr_ovf = 1'b0;
    @(negedge clk) check_ovf(1'b0);
    @(posedge clk) #1 begin kbd_overflow = 1'b1; clr_ovf = 1'b1; end
    @(posedge clk) #1 begin kbd_overflow = 1'b0; clr_ovf = 1'b0; end
    @(negedge clk) check_ovf(1'b1);
    @(posedge clk) #1 clr_ovf = 1'b1;
    @(posedge clk) #1 clr_ovf = 1'b0;

    // Counter wrap past 8 bits
    for (int k = 0; k < 258; k++) begin
      push2(8'h15); push2(8'hF0); push2(8'h15);
      push2((k % 2 == 0) ? 8'h00 : 8'hFF);
    end
    wait_drain();
    counts2();

    // Randomized traffic with random consumer stalls
    rnd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      c = codes[$urandom_range(4)];
      case ($urandom_range(9))
        0, 1, 2, 3: push2(c);
        4:          begin push2(8'hE0); push2(c); end
        5, 6:       begin push2(8'hF0); push2(c); end
        7:          begin push2(8'hE0); push2(8'hF0); push2(c); end
        8:          push2(($urandom_range(1) == 0) ? 8'h00 : 8'hFF);
        default:    begin push2(c); push2(c); end
      endcase
    end
    wait_drain();
    rnd_ready = 1'b0;
    @(posedge clk) #2 evt_ready = 1'b1;
    counts2();

    // Asynchronous reset while an event is pending
    @(posedge clk) #1 evt_ready = 1'b0;
    push2(8'hF0); push2(8'h2A);
    t = 0;
    while (t < 200 && !(g_ch[0].evt_valid && g_ch[1].evt_valid)) begin
      @(negedge clk);
      t++;
    end
    chk(9, "emit_reached", t < 200, 1);
    #2 clrn = 1'b0;
    #1;
    chk(0, "async_clr_valid", g_ch[0].evt_valid, 0);
    chk(1, "async_clr_valid", g_ch[1].evt_valid, 0);
    g_ch[0].reset_model();
    g_ch[1].reset_model();
    @(negedge clk);
    g_ch[0].check_reset();
    g_ch[1].check_reset();
    @(posedge clk) #1 begin clrn = 1'b1; evt_ready = 1'b1; end
    p1 = g_ch[1].pops;
    push2(8'h1C);
    wait_drain();
    counts2();
    chk(1, "pops_after_rst", g_ch[1].pops - p1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
